// File: rtl/fibonacci_core_if.sv
// fibonacci_core_if -- control inputs and pad outputs of the Fibonacci core.
// master drives the controls, slave is the core side.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

interface fibonacci_core_if #(
   parameter int CLOCK_WIDTH = 6
) ();
   logic [CLOCK_WIDTH-1:0]   clock_op;
   logic                     switch_in;
   logic                     restart;
   logic [`MPRJ_IO_PADS-1:0] io_out;
   logic [`MPRJ_IO_PADS-1:0] io_oeb;
   logic                     wrap_o;
   logic [15:0]              step_cnt;

   modport master (
      output clock_op, switch_in, restart,
      input  io_out, io_oeb, wrap_o, step_cnt
   );

   modport slave (
      input  clock_op, switch_in, restart,
      output io_out, io_oeb, wrap_o, step_cnt
   );
endinterface

// File: rtl/fibonacci_core.sv
// fibonacci_core -- prescaled Fibonacci sequence shown on io_out[37:8].
// Optional step counter enabled by defining FIBONACCI_STEP_CNT_EN.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module fibonacci_core #(
   parameter int CLOCK_WIDTH = 6,
   parameter int VAL_WIDTH   = 30
) (
   input logic             wb_clk_i,
   input logic             reset,
   fibonacci_core_if.slave bus
);
   localparam int PADS = `MPRJ_IO_PADS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [VAL_WIDTH-1:0]   fib_a;
   logic [VAL_WIDTH-1:0]   fib_b;
   logic [VAL_WIDTH:0]     fib_sum;
   logic                   carry;
   logic [CLOCK_WIDTH-1:0] div_cnt;
   logic [CLOCK_WIDTH-1:0] eff;
   logic [CLOCK_WIDTH:0]   div_inc;
   logic                   tick;
   logic                   wrap_q;
   logic [PADS-1:0]        io_q;
   logic [PADS-1:0]        oeb_q;

   always_ff @(posedge wb_clk_i or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.switch_in)  state_nxt = RUN;
         RUN:     if (!bus.switch_in) state_nxt = PAUSE;
         PAUSE:   if (bus.switch_in)  state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // >= compare so a shrinking clock_op ticks at once instead of wrapping
   always_comb begin
      eff     = (bus.clock_op == '0) ? CLOCK_WIDTH'(1) : bus.clock_op;
      div_inc = {1'b0, div_cnt} + (CLOCK_WIDTH+1)'(1);
      tick    = (state == RUN) && (div_inc >= {1'b0, eff});
      fib_sum = {1'b0, fib_a} + {1'b0, fib_b};
      carry   = fib_sum[VAL_WIDTH];
   end

   always_ff @(posedge wb_clk_i or posedge reset) begin
      if (reset) begin
         fib_a   <= '0;
         fib_b   <= VAL_WIDTH'(1);
         div_cnt <= '0;
         wrap_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (bus.restart) begin
            fib_a   <= '0;
            fib_b   <= VAL_WIDTH'(1);
            div_cnt <= '0;
         end else if (tick) begin
            div_cnt <= '0;
            if (carry) begin
               fib_a  <= '0;
               fib_b  <= VAL_WIDTH'(1);
               wrap_q <= 1'b1;
            end else begin
               fib_a <= fib_b;
               fib_b <= fib_sum[VAL_WIDTH-1:0];
            end
         end else if (state == RUN) begin
            div_cnt <= div_inc[CLOCK_WIDTH-1:0];
         end else begin
            div_cnt <= '0;
         end
      end
   end

   always_comb begin
      io_q                  = '0;
      io_q[VAL_WIDTH+7:8]   = fib_a;
      oeb_q                 = '0;
      oeb_q[7:0]            = 8'hFF;
   end

   assign bus.io_out = io_q;
   assign bus.io_oeb = oeb_q;
   assign bus.wrap_o = wrap_q;

`ifdef FIBONACCI_STEP_CNT_EN
   logic [15:0] step_q;

   always_ff @(posedge wb_clk_i or posedge reset) begin
      if (reset)            step_q <= '0;
      else if (bus.restart) step_q <= '0;
      else if (tick)        step_q <= step_q + 16'd1;
   end

   assign bus.step_cnt = step_q;
`else
   assign bus.step_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fibonacci_core.sv
// tb_fibonacci_core -- scoreboard bench for fibonacci_core.
// Step counter expectations follow FIBONACCI_STEP_CNT_EN.
`timescale 1ns/1ps

module tb_fibonacci_core;
   typedef logic [29:0] val_t;

`ifdef FIBONACCI_STEP_CNT_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   val_t exp_val_q[$];
   bit   exp_wrap_q[$];

   always #5 clk = ~clk;

   fibonacci_core_if #(.CLOCK_WIDTH(6)) bus ();

   fibonacci_core #(
      .CLOCK_WIDTH(6),
      .VAL_WIDTH(30)
   ) dut (
      .wb_clk_i (clk),
      .reset    (rst),
      .bus      (bus)
   );

   function automatic longint fib(int k);
      longint a = 0;
      longint b = 1;
      longint t;
      for (int i = 0; i < k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic logic [15:0] exp_step(int n);
      return STEP_EN ? 16'(n) : 16'h0000;
   endfunction

   task automatic test_reset();
      val_t got, e;
      rst = 1'b1;
      bus.clock_op = 6'd1;
      bus.switch_in = 1'b0;
      bus.restart = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.io_out !== 38'h0) begin
         n_err++;
         $display("FAIL rst_io_out got %h want 0", bus.io_out);
      end
      n_cmp++;
      if (bus.wrap_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_wrap got %b want 0", bus.wrap_o);
      end
      n_cmp++;
      if (bus.step_cnt !== 16'h0) begin
         n_err++;
         $display("FAIL rst_step got %0d want 0", bus.step_cnt);
      end
      n_cmp++;
      if (bus.io_oeb !== 38'h00_0000_00FF) begin
         n_err++;
         $display("FAIL rst_oeb got %h want ff", bus.io_oeb);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) exp_val_q.push_back(val_t'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL idle_hold[%0d] got %0d want %0d", i, got, e);
         end
      end
      n_cmp++;
      if (bus.io_oeb !== 38'h00_0000_00FF) begin
         n_err++;
         $display("FAIL oeb_after_rst got %h want ff", bus.io_oeb);
      end
   endtask

   task automatic test_sequence();
      val_t got, e;
      bus.clock_op = 6'd1;
      bus.switch_in = 1'b1;
      for (int i = 0; i < 7; i++) exp_val_q.push_back(val_t'(fib(i)));
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e || bus.io_out[7:0] !== 8'h0) begin
            n_err++;
            $display("FAIL seq[%0d] got %0d/%h want %0d", i, got,
                     bus.io_out[7:0], e);
         end
      end
      n_cmp++;
      if (bus.step_cnt !== exp_step(6)) begin
         n_err++;
         $display("FAIL seq_step got %0d want %0d", bus.step_cnt,
                  exp_step(6));
      end
   endtask

   task automatic test_pause_resume();
      val_t got, e;
      bus.switch_in = 1'b0;
      for (int i = 0; i < 11; i++) exp_val_q.push_back(val_t'(13));
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL pause[%0d] got %0d want %0d", i, got, e);
         end
      end
      bus.switch_in = 1'b1;
      bus.clock_op = 6'd2;
      exp_val_q.push_back(val_t'(13));
      exp_val_q.push_back(val_t'(13));
      exp_val_q.push_back(val_t'(21));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL resume[%0d] got %0d want %0d", i, got, e);
         end
      end
      n_cmp++;
      if (bus.step_cnt !== exp_step(8)) begin
         n_err++;
         $display("FAIL resume_step got %0d want %0d", bus.step_cnt,
                  exp_step(8));
      end
   endtask

   task automatic test_prescale();
      val_t got, e;
      int   exp3[11] = '{0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2};
      bus.restart = 1'b1;
      bus.clock_op = 6'd3;
      @(negedge clk);
      bus.restart = 1'b0;
      n_cmp++;
      if (bus.io_out[37:8] !== 30'd0 || bus.step_cnt !== 16'h0) begin
         n_err++;
         $display("FAIL pre_restart got %0d/%0d want 0/0",
                  bus.io_out[37:8], bus.step_cnt);
      end
      for (int i = 0; i < 11; i++) exp_val_q.push_back(val_t'(exp3[i]));
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL div3[%0d] got %0d want %0d", i, got, e);
         end
      end
      bus.clock_op = 6'd0;
      exp_val_q.push_back(val_t'(3));
      exp_val_q.push_back(val_t'(5));
      exp_val_q.push_back(val_t'(8));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL div0[%0d] got %0d want %0d", i, got, e);
         end
      end
      bus.clock_op = 6'd5;
      for (int i = 0; i < 3; i++) exp_val_q.push_back(val_t'(8));
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            bus.clock_op = 6'd2;
            exp_val_q.push_back(val_t'(13));
         end
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL shrink[%0d] got %0d want %0d", i, got, e);
         end
      end
      exp_val_q.push_back(val_t'(13));
      exp_val_q.push_back(val_t'(21));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL div2[%0d] got %0d want %0d", i, got, e);
         end
      end
   endtask

   task automatic test_wrap();
      val_t got, e;
      bit   ew;
      bus.restart = 1'b1;
      bus.clock_op = 6'd1;
      @(negedge clk);
      bus.restart = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         if (k <= 43)      exp_val_q.push_back(val_t'(fib(k)));
         else if (k == 44) exp_val_q.push_back(val_t'(0));
         else              exp_val_q.push_back(val_t'(1));
         exp_wrap_q.push_back(k == 44);
      end
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         ew = exp_wrap_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e || bus.wrap_o !== ew) begin
            n_err++;
            $display("FAIL wrap_seq[%0d] got %0d/%b want %0d/%b", k, got,
                     bus.wrap_o, e, ew);
         end
         if (k == 43) begin
            n_cmp++;
            if (got !== 30'd433494437) begin
               n_err++;
               $display("FAIL f43 got %0d want 433494437", got);
            end
         end
         if (k == 44) begin
            n_cmp++;
            if (bus.step_cnt !== exp_step(44)) begin
               n_err++;
               $display("FAIL wrap_step got %0d want %0d", bus.step_cnt,
                        exp_step(44));
            end
         end
      end
   endtask

   task automatic test_restart_tick();
      val_t got, e;
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      for (int k = 1; k <= 10; k++) exp_val_q.push_back(val_t'(fib(k)));
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL rs_seq[%0d] got %0d want %0d", k, got, e);
         end
      end
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      n_cmp++;
      if (bus.io_out[37:8] !== 30'd0 || bus.wrap_o !== 1'b0 ||
          bus.step_cnt !== 16'h0) begin
         n_err++;
         $display("FAIL rs_tick got %0d/%b/%0d want 0/0/0",
                  bus.io_out[37:8], bus.wrap_o, bus.step_cnt);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.io_out[37:8] !== 30'd1) begin
         n_err++;
         $display("FAIL rs_next got %0d want 1", bus.io_out[37:8]);
      end
      bus.switch_in = 1'b0;
      @(negedge clk);
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      for (int i = 0; i < 4; i++) exp_val_q.push_back(val_t'(0));
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL rs_pause[%0d] got %0d want %0d", i, got, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      val_t got, e;
      bus.switch_in = 1'b1;
      bus.clock_op = 6'd2;
      for (int i = 1; i <= 24; i++)
         exp_val_q.push_back(val_t'(fib((i - 1) / 2)));
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL mid_seq[%0d] got %0d want %0d", i, got, e);
         end
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.io_out !== 38'h0 || bus.wrap_o !== 1'b0 ||
          bus.step_cnt !== 16'h0) begin
         n_err++;
         $display("FAIL mid_async got %h/%b/%0d want 0/0/0", bus.io_out,
                  bus.wrap_o, bus.step_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.clock_op = 6'd1;
      bus.switch_in = 1'b0;
      for (int i = 0; i < 3; i++) exp_val_q.push_back(val_t'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL mid_idle[%0d] got %0d want %0d", i, got, e);
         end
      end
   endtask

   task automatic test_reset_wrap();
      val_t got, e;
      int   slow[4] = '{0, 0, 0, 1};
      bus.switch_in = 1'b1;
      bus.clock_op = 6'd1;
      repeat (44) @(negedge clk);
      n_cmp++;
      if (bus.io_out[37:8] !== 30'd433494437) begin
         n_err++;
         $display("FAIL rw_f43 got %0d want 433494437", bus.io_out[37:8]);
      end
      #2 rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.wrap_o !== 1'b0 || bus.io_out !== 38'h0) begin
            n_err++;
            $display("FAIL rw_abort[%0d] got %b/%h want 0/0", i,
                     bus.wrap_o, bus.io_out);
         end
      end
      rst = 1'b0;
      bus.clock_op = 6'd3;
      for (int i = 0; i < 4; i++) exp_val_q.push_back(val_t'(slow[i]));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = exp_val_q.pop_front();
         got = bus.io_out[37:8];
         n_cmp++;
         if (got !== e || bus.wrap_o !== 1'b0) begin
            n_err++;
            $display("FAIL first_tick[%0d] got %0d/%b want %0d/0", i, got,
                     bus.wrap_o, e);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sequence();
      test_pause_resume();
      test_prescale();
      test_wrap();
      test_restart_tick();
      test_reset_mid();
      test_reset_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
